// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters with sync,
// blanking and frame-start outputs. All outputs are registered and always
// describe the x,y value presented in the same cycle.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  output logic        HS,
  output logic        VS,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        blank,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [9:0]  V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]  VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        blank_q, blank_d;
  logic        frame_start_q, frame_start_d;

  // Next counter values; the decoded outputs below are derived from these so
  // that sync and blank line up with the counters once registered.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    if (CE) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 11'd1;
      end
    end
  end

  // Sync and blank decode of the next position.
  always_comb begin
    hs_d    = ((x_d >= HS_START) && (x_d < HS_END)) ? HS_POL : ~HS_POL;
    vs_d    = ((y_d >= VS_START) && (y_d < VS_END)) ? VS_POL : ~VS_POL;
    blank_d = (x_d >= H_VIS_END) || (y_d >= V_VIS_END);
  end

  // State registers; reset puts the raster at the origin with syncs idle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x_q           <= '0;
      y_q           <= '0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign HS          = hs_q;
  assign VS          = vs_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: one instance at standard 640x480
// timing, one at a tiny raster with inverted sync polarity so whole frames
// fit in a short run. A CE-count model predicts every output each cycle.
module tb_vga_timing_gen;

  localparam int FRAME_A = 800 * 525;
  localparam int FRAME_B = 15 * 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CE  = 1'b1;

  logic        hsA, vsA, blankA, fsA;
  logic [10:0] xA;
  logic [9:0]  yA;
  logic        hsB, vsB, blankB, fsB;
  logic [10:0] xB;
  logic [9:0]  yB;

  int assertCount = 0;
  int failCount   = 0;

  int ceCount = 0;
  bit fsExpA  = 1'b0;
  bit fsExpB  = 1'b0;

  vga_timing_gen dutA (
    .CLK(CLK), .RST(RST), .CE(CE),
    .HS(hsA), .VS(vsA), .x(xA), .y(yA), .blank(blankA), .frame_start(fsA)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dutB (
    .CLK(CLK), .RST(RST), .CE(CE),
    .HS(hsB), .VS(vsB), .x(xB), .y(yB), .blank(blankB), .frame_start(fsB)
  );

  // Pixel clock.
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit ce, input int cycles);
    RST = rst;
    CE  = ce;
    repeat (cycles) @(negedge CLK);
    #1;
  endtask

  // Raster position and decoded outputs as a function of CE-cycles since reset.
  function automatic void predict(input int n, input int hv, input int hf, input int hsw,
                                  input int hb, input int vv, input int vf, input int vsw,
                                  input int vb, input bit hpol, input bit vpol,
                                  output int ex, output int ey, output bit ehs,
                                  output bit evs, output bit eblank);
    int ht, vt;
    ht     = hv + hf + hsw + hb;
    vt     = vv + vf + vsw + vb;
    ex     = n % ht;
    ey     = (n / ht) % vt;
    eblank = (ex >= hv) || (ey >= vv);
    ehs    = (ex >= hv + hf && ex < hv + hf + hsw) ? hpol : ~hpol;
    evs    = (ey >= vv + vf && ey < vv + vf + vsw) ? vpol : ~vpol;
  endfunction

  // Reference model: counts CE-qualified edges and flags frame wraps.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      ceCount = 0;
      fsExpA  = 1'b0;
      fsExpB  = 1'b0;
    end else if (CE) begin
      ceCount = ceCount + 1;
      fsExpA  = (ceCount % FRAME_A) == 0;
      fsExpB  = (ceCount % FRAME_B) == 0;
    end else begin
      fsExpA  = 1'b0;
      fsExpB  = 1'b0;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge CLK) begin
    int ex, ey;
    bit ehs, evs, eblank;
    predict(ceCount, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, ex, ey, ehs, evs, eblank);
    checkOutput("A.x", int'(xA), ex);
    checkOutput("A.y", int'(yA), ey);
    checkOutput("A.HS", int'(hsA), int'(ehs));
    checkOutput("A.VS", int'(vsA), int'(evs));
    checkOutput("A.blank", int'(blankA), int'(eblank));
    checkOutput("A.frame_start", int'(fsA), int'(fsExpA));
    predict(ceCount, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b1, ex, ey, ehs, evs, eblank);
    checkOutput("B.x", int'(xB), ex);
    checkOutput("B.y", int'(yB), ey);
    checkOutput("B.HS", int'(hsB), int'(ehs));
    checkOutput("B.VS", int'(vsB), int'(evs));
    checkOutput("B.blank", int'(blankB), int'(eblank));
    checkOutput("B.frame_start", int'(fsB), int'(fsExpB));
  end

  // Directed sequence with hand-computed checkpoints.
  initial begin
    int nBefore, guard, period;

    applyStimulus(1'b1, 1'b1, 3);
    checkOutput("rst A.x", int'(xA), 0);
    checkOutput("rst A.y", int'(yA), 0);
    checkOutput("rst A.HS", int'(hsA), 1);
    checkOutput("rst A.VS", int'(vsA), 1);
    checkOutput("rst A.blank", int'(blankA), 0);
    checkOutput("rst A.frame_start", int'(fsA), 0);
    checkOutput("rst B.HS", int'(hsB), 0);
    checkOutput("rst B.VS", int'(vsB), 0);

    // 80 cycles: small raster at x=5,y=5 (vertical sync active, high).
    applyStimulus(1'b0, 1'b1, 80);
    checkOutput("c80 B.y", int'(yB), 5);
    checkOutput("c80 B.VS", int'(vsB), 1);
    checkOutput("c80 B.blank", int'(blankB), 1);
    checkOutput("c80 A.x", int'(xA), 80);

    // 120 cycles: small raster wraps to origin with frame_start.
    applyStimulus(1'b0, 1'b1, 40);
    checkOutput("c120 B.x", int'(xB), 0);
    checkOutput("c120 B.y", int'(yB), 0);
    checkOutput("c120 B.frame_start", int'(fsB), 1);

    applyStimulus(1'b0, 1'b1, 520);
    checkOutput("c640 A.blank", int'(blankA), 1);
    checkOutput("c640 A.HS", int'(hsA), 1);
    applyStimulus(1'b0, 1'b1, 16);
    checkOutput("c656 A.HS", int'(hsA), 0);
    applyStimulus(1'b0, 1'b1, 95);
    checkOutput("c751 A.HS", int'(hsA), 0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("c752 A.HS", int'(hsA), 1);
    applyStimulus(1'b0, 1'b1, 48);
    checkOutput("c800 A.x", int'(xA), 0);
    checkOutput("c800 A.y", int'(yA), 1);
    checkOutput("c800 A.blank", int'(blankA), 0);
    checkOutput("c800 A.frame_start", int'(fsA), 0);

    // Frame period of the small raster, bounded waits.
    guard = 0;
    while (!fsB && guard < 200) begin
      applyStimulus(1'b0, 1'b1, 1);
      guard++;
    end
    checkOutput("B frame_start seen", int'(fsB), 1);
    period = 0;
    do begin
      applyStimulus(1'b0, 1'b1, 1);
      period++;
    end while (!fsB && period < 200);
    checkOutput("B frame period", period, FRAME_B);

    // CE toggling: only enabled edges advance the counters.
    nBefore = ceCount;
    repeat (20) begin
      applyStimulus(1'b0, 1'b0, 1);
      checkOutput("ce0 A.frame_start", int'(fsA), 0);
      applyStimulus(1'b0, 1'b1, 1);
    end
    checkOutput("ce toggle A.x", int'(xA), (nBefore + 20) % 800);

    // Run to x=700 (horizontal sync active), then reset asynchronously.
    guard = 0;
    while ((ceCount % 800) != 700 && guard < 2000) begin
      applyStimulus(1'b0, 1'b1, 1);
      guard++;
    end
    checkOutput("reach A.x", int'(xA), 700);
    checkOutput("x700 A.HS", int'(hsA), 0);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("async A.x", int'(xA), 0);
    checkOutput("async A.y", int'(yA), 0);
    checkOutput("async A.HS", int'(hsA), 1);
    checkOutput("async A.VS", int'(vsA), 1);
    checkOutput("async A.blank", int'(blankA), 0);
    checkOutput("async B.HS", int'(hsB), 0);
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b0, 1'b1, 30);
    checkOutput("restart A.x", int'(xA), 30);
    checkOutput("restart A.y", int'(yA), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
